// File: rtl/uart_text_pkg.sv
// Shared constants and state type for the UART text screen.
package uart_text_pkg;

   // Control characters interpreted by the screen
   localparam logic [7:0] BS  = 8'h08;
   localparam logic [7:0] DEL = 8'h7F;
   localparam logic [7:0] LF  = 8'h0A;
   localparam logic [7:0] CR  = 8'h0D;
   localparam logic [7:0] FF  = 8'h0C;

   typedef enum logic [1:0] {
      CLEAR_ALL = 2'd0,
      IDLE      = 2'd1,
      CLEAR_ROW = 2'd2
   } state_e;

endpackage

// File: rtl/uart_text_screen_if.sv
// Byte-stream valid/ready handshake from the UART receiver into the screen.
interface uart_text_screen_if;
   logic       inValid;
   logic [7:0] inByte;
   logic       inReady;

   modport master (output inValid, output inByte, input inReady);
   modport slave  (input inValid, input inByte, output inReady);
endinterface

// File: rtl/text_ram.sv
// Character store: one synchronous write port, one registered read port.
// A same-cycle read of the cell being written returns the old value.
module text_ram #(
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [7:0]               wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [7:0]               rdata
);

   logic [7:0] mem_q [DEPTH];
   logic [7:0] rdata_q;

   // Write and registered read share the edge; NBA ordering gives read-old
   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
      rdata_q <= mem_q[raddr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/uart_text_screen.sv
// ROWS x COLS text screen fed by a byte stream: cursor, wrap, control
// characters and hardware scrolling via a rotating top-row pointer.
module uart_text_screen
   import uart_text_pkg::*;
#(
   parameter int         COLS  = 16,
   parameter int         ROWS  = 4,
   parameter logic [7:0] BLANK = 8'h20
) (
   input  logic                    clk,
   input  logic                    rst_n,
   uart_text_screen_if.slave       in_if,
   input  logic [$clog2(ROWS)-1:0] rdRow,
   input  logic [$clog2(COLS)-1:0] rdCol,
   output logic [7:0]              rdByte,
   output logic [$clog2(ROWS)-1:0] cursorRow,
   output logic [$clog2(COLS)-1:0] cursorCol
);

   localparam int RW    = $clog2(ROWS);
   localparam int CW    = $clog2(COLS);
   localparam int AW    = RW + CW;
   localparam int NCELL = ROWS * COLS;

   localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
   localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
   localparam logic [AW-1:0] LAST_CELL = AW'(NCELL - 1);

   state_e        state_q, state_d;
   logic [AW-1:0] clr_q, clr_d;
   logic [RW-1:0] top_q, top_d;
   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic          ready_q, ready_d;

   logic          we;
   logic [AW-1:0] waddr;
   logic [7:0]    wdata;
   logic [7:0]    ram_rdata;
   logic          adv;

   // Logical-to-physical row mapping; natural RW-bit wraparound
   logic [RW-1:0] phys_cur, phys_up, phys_bot, phys_rd;
   logic [CW-1:0] col_m1;

   assign phys_cur = row_q + top_q;
   assign phys_up  = row_q - RW'(1) + top_q;
   assign phys_bot = LAST_ROW + top_q;
   assign phys_rd  = rdRow + top_q;
   assign col_m1   = col_q - CW'(1);

   text_ram #(.DEPTH(NCELL)) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr ({phys_rd, rdCol}),
      .rdata (ram_rdata)
   );

   // Next-state, cursor movement and RAM write port
   always_comb begin
      state_d = state_q;
      clr_d   = clr_q;
      top_d   = top_q;
      row_d   = row_q;
      col_d   = col_q;
      we      = 1'b0;
      waddr   = {phys_cur, col_q};
      wdata   = BLANK;
      adv     = 1'b0;

      case (state_q)
         CLEAR_ALL: begin
            // Linear sweep over every physical cell, then home everything
            we    = 1'b1;
            waddr = clr_q;
            clr_d = clr_q + AW'(1);
            if (clr_q == LAST_CELL) begin
               state_d = IDLE;
               clr_d   = '0;
               top_d   = '0;
               row_d   = '0;
               col_d   = '0;
            end
         end

         CLEAR_ROW: begin
            // Blank the row that just became the bottom of the screen
            we    = 1'b1;
            waddr = {phys_bot, clr_q[CW-1:0]};
            clr_d = clr_q + AW'(1);
            if (clr_q[CW-1:0] == LAST_COL) begin
               state_d = IDLE;
               clr_d   = '0;
            end
         end

         IDLE: begin
            if (in_if.inValid) begin
               case (in_if.inByte)
                  BS, DEL: begin
                     if (col_q != '0) begin
                        col_d = col_m1;
                        we    = 1'b1;
                        waddr = {phys_cur, col_m1};
                     end else if (row_q != '0) begin
                        row_d = row_q - RW'(1);
                        col_d = LAST_COL;
                        we    = 1'b1;
                        waddr = {phys_up, LAST_COL};
                     end
                  end
                  CR: col_d = '0;
                  LF: begin
                     col_d = '0;
                     adv   = 1'b1;
                  end
                  FF: begin
                     state_d = CLEAR_ALL;
                     clr_d   = '0;
                  end
                  default: begin
                     we    = 1'b1;
                     wdata = in_if.inByte;
                     if (col_q == LAST_COL) begin
                        col_d = '0;
                        adv   = 1'b1;
                     end else begin
                        col_d = col_q + CW'(1);
                     end
                  end
               endcase
            end
         end

         default: begin
            state_d = CLEAR_ALL;
            clr_d   = '0;
         end
      endcase

      // Row advance; at the bottom the screen scrolls instead
      if (adv) begin
         if (row_q != LAST_ROW) begin
            row_d = row_q + RW'(1);
         end else begin
            top_d   = top_q + RW'(1);
            state_d = CLEAR_ROW;
            clr_d   = '0;
         end
      end

      ready_d = (state_d == IDLE);
   end

   // FSM and cursor registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= CLEAR_ALL;
         clr_q   <= '0;
         top_q   <= '0;
         row_q   <= '0;
         col_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         clr_q   <= clr_d;
         top_q   <= top_d;
         row_q   <= row_d;
         col_q   <= col_d;
         ready_q <= ready_d;
      end
   end

   assign in_if.inReady = ready_q;
   assign cursorRow     = row_q;
   assign cursorCol     = col_q;
   // Stale or uninitialised RAM contents are hidden during a full clear
   assign rdByte        = (state_q == CLEAR_ALL) ? BLANK : ram_rdata;

endmodule

// File: tb/tb_uart_text_screen.sv
// Directed bench for uart_text_screen with a logical-screen reference model.
module tb_uart_text_screen;
   import uart_text_pkg::*;

   localparam int ROWS = 4;
   localparam int COLS = 16;
   localparam int NC   = ROWS * COLS;
   localparam logic [7:0] BL = 8'h20;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] rdRow;
   logic [3:0] rdCol;
   logic [7:0] rdByte;
   logic [1:0] cRow;
   logic [3:0] cCol;

   uart_text_screen_if bus();

   uart_text_screen #(.COLS(COLS), .ROWS(ROWS), .BLANK(BL)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_if     (bus.slave),
      .rdRow     (rdRow),
      .rdCol     (rdCol),
      .rdByte    (rdByte),
      .cursorRow (cRow),
      .cursorCol (cCol)
   );

   always #5 clk = ~clk;

   // Reference model: the screen as seen by the reader (logical rows)
   logic [7:0] scr [ROWS][COLS];
   int         m_row, m_col, busy;
   bit         m_clrall, m_acc;
   int         vecs = 0, errs = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic void blank_all();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) scr[r][c] = BL;
   endfunction

   function automatic void next_row();
      if (m_row < ROWS - 1) m_row++;
      else begin
         for (int r = 0; r < ROWS - 1; r++) scr[r] = scr[r + 1];
         for (int c = 0; c < COLS; c++) scr[ROWS - 1][c] = BL;
         busy = COLS;
      end
   endfunction

   function automatic void apply(input logic [7:0] b);
      case (b)
         BS, DEL: begin
            if (m_col > 0) begin m_col--; scr[m_row][m_col] = BL; end
            else if (m_row > 0) begin m_row--; m_col = COLS - 1; scr[m_row][m_col] = BL; end
         end
         CR: m_col = 0;
         LF: begin m_col = 0; next_row(); end
         FF: begin busy = NC; m_clrall = 1; blank_all(); end
         default: begin
            scr[m_row][m_col] = b;
            if (m_col == COLS - 1) begin m_col = 0; next_row(); end
            else m_col++;
         end
      endcase
   endfunction

   // One clock: advance the model with the driven inputs, then compare all outputs
   task automatic step();
      logic [7:0] rd_exp;
      bit         rd_ok;
      rd_ok = 0;
      rd_exp = BL;
      m_acc = 0;
      @(posedge clk);
      if (!rst_n) begin
         busy = NC; m_clrall = 1; m_row = 0; m_col = 0; blank_all();
      end else if (busy > 0) begin
         busy--;
         if (busy == 0 && m_clrall) begin m_clrall = 0; m_row = 0; m_col = 0; end
      end else begin
         rd_exp = scr[rdRow][rdCol];
         rd_ok  = 1;
         if (bus.inValid) begin m_acc = 1; apply(bus.inByte); end
      end
      if (busy > 0 && m_clrall) begin rd_exp = BL; rd_ok = 1; end
      #1;
      chk("inReady", {31'b0, bus.inReady}, {31'b0, busy == 0});
      chk("cursorRow", {30'b0, cRow}, m_row);
      chk("cursorCol", {28'b0, cCol}, m_col);
      if (rd_ok) chk("rdByte", {24'b0, rdByte}, {24'b0, rd_exp});
      @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      bus.inValid = 1'b1;
      bus.inByte  = b;
      do begin step(); n++; end while (!m_acc && n < 500);
      if (!m_acc) chk("send_timeout", n, 0);
      bus.inValid = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i]);
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (bus.inReady !== 1'b1 && n < 500) begin step(); n++; end
   endtask

   task automatic rd_lit(input string nm, input int r, input int c, input logic [7:0] exp);
      rdRow = 2'(r);
      rdCol = 4'(c);
      step();
      chk(nm, {24'b0, rdByte}, {24'b0, exp});
   endtask

   task automatic sweep();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) begin
            rdRow = 2'(r); rdCol = 4'(c); step();
         end
   endtask

   task automatic cur_lit(input string nm, input int r, input int c);
      chk({nm, "_row"}, {30'b0, cRow}, r);
      chk({nm, "_col"}, {28'b0, cCol}, c);
   endtask

   int  n;
   bit  dropped;

   initial begin
      rst_n = 1'b0;
      bus.inValid = 1'b0;
      bus.inByte  = 8'h00;
      rdRow = '0;
      rdCol = '0;
      m_row = 0; m_col = 0; busy = NC; m_clrall = 1;
      blank_all();
      @(negedge clk);
      repeat (3) step();
      chk("rst_ready", {31'b0, bus.inReady}, 0);
      chk("rst_rd", {24'b0, rdByte}, 32'h20);

      // Reset clear
      rst_n = 1'b1;
      wait_ready(n);
      chk("clr_cycles", n, 64);
      cur_lit("clr_cur", 0, 0);
      sweep();

      // Wrap at full throughput
      dropped = 0;
      for (int i = 0; i < 17; i++) begin
         send(8'h41 + 8'(i));
         if (bus.inReady !== 1'b1) dropped = 1;
      end
      chk("wrap_nodrop", {31'b0, dropped}, 0);
      cur_lit("wrap_cur", 1, 1);
      rd_lit("wrap_a", 0, 0, "A");
      rd_lit("wrap_p", 0, 15, "P");
      rd_lit("wrap_q", 1, 0, "Q");

      // Form feed then scroll
      send(FF);
      wait_ready(n);
      chk("ff_cycles", n, 64);
      cur_lit("ff_cur", 0, 0);
      for (int i = 0; i < 16 * 3 + 15; i++) send(8'h30 + 8'(i / 16));
      cur_lit("fill_cur", 3, 15);
      send(LF);
      wait_ready(n);
      chk("scroll_cycles", n, 16);
      cur_lit("scroll_cur", 3, 0);
      rd_lit("scroll_r0", 0, 0, "1");
      rd_lit("scroll_r2", 2, 14, "3");
      rd_lit("scroll_r3", 3, 5, BL);
      sweep();

      // Backspace
      send(FF);
      wait_ready(n);
      send_str("AB");
      send(BS);
      cur_lit("bs_cur", 0, 1);
      rd_lit("bs_cell", 0, 1, BL);
      for (int i = 0; i < 14; i++) send("x");
      send("y");
      cur_lit("pre_del", 1, 0);
      send(DEL);
      cur_lit("del_cur", 0, 15);
      rd_lit("del_cell", 0, 15, BL);
      send(CR);
      send(BS);
      cur_lit("bs00_cur", 0, 0);
      rd_lit("bs00_cell", 0, 0, "A");

      // CR overwrite
      send_str("ab");
      send(CR);
      send("Z");
      rd_lit("cr_z", 0, 0, "Z");
      rd_lit("cr_b", 0, 1, "b");
      cur_lit("cr_cur", 0, 1);

      // Held input across a scroll is taken exactly once
      send(LF); send(LF); send(LF);
      send(LF);
      n = 0;
      bus.inValid = 1'b1;
      bus.inByte  = "X";
      do begin step(); n++; end while (!m_acc && n < 500);
      bus.inValid = 1'b0;
      chk("hold_wait", n, 17);
      step();
      cur_lit("hold_cur", 3, 1);
      rd_lit("hold_x", 3, 0, "X");
      rd_lit("hold_once", 3, 1, BL);

      // Reset in the middle of a full clear restarts it
      send_str("garbage");
      send(FF);
      repeat (10) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      wait_ready(n);
      chk("rst_mid_cycles", n, 64);
      cur_lit("rst_mid_cur", 0, 0);
      sweep();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/uart_text_screen.md
# uart_text_screen

Multi-row, parametrised successor of the single-row UART text buffer. Accepts a byte stream over a valid/ready handshake and maintains a ROWS×COLS character screen with a cursor, line wrap, control-character handling and hardware scrolling. Sits between the UART receiver and the screen character renderer. The renderer reads characters through a registered random-access port.

## Interface
- COLS, 16: characters per row; power of two, ≥4.
- ROWS, 4: rows on screen; power of two, ≥2.
- BLANK, 8'h20: fill character written by clear, scroll and backspace.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- inValid  in  1  inByte is valid this cycle.
- inByte  in  8  received character.
- inReady  out  1  block can accept a byte; a transfer happens on an edge where inValid && inReady.
- rdRow  in  $clog2(ROWS)  logical row to read; 0 is the top of the screen.
- rdCol  in  $clog2(COLS)  column to read.
- rdByte  out  8  character at (rdRow, rdCol), registered.
- cursorRow  out  $clog2(ROWS)  logical row of the next write.
- cursorCol  out  $clog2(COLS)  column of the next write.

## Operation
- **Storage:** ROWS×COLS bytes.
  - Physical row = (logical row + topRow) mod ROWS.
  - topRow is an internal pointer with natural wraparound.
- **FSM states:** CLEAR_ALL, IDLE, CLEAR_ROW.
  - inReady = 1 only in IDLE.
  - A single counter clrIdx is used by both clear states.
- **CLEAR_ALL:**
  - Writes BLANK to one cell per cycle, linear index 0 .. ROWS*COLS-1.
  - Then sets topRow=0, cursor=(0,0), and goes to IDLE.
  - While in CLEAR_ALL, rdByte is forced to BLANK.
- **CLEAR_ROW:**
  - Writes BLANK to the physical row indexed by the new bottom row, one column per cycle, COLS cycles.
  - Then goes to IDLE.
- **Accepted byte in IDLE:**
  - 0x08 or 0x7F, backspace:
    - If col>0: col−1, then write BLANK at the new position.
    - Else if row>0: move to (row−1, COLS−1) and blank that cell.
    - At (0,0): no effect.
    - Backspace never scrolls back.
  - 0x0D: col=0.
  - 0x0A: col=0 and advance the row.
  - 0x0C: go to CLEAR_ALL.
  - Any other value: write it at the cursor, then col+1. If col was COLS−1: col=0 and advance the row.
- **Advance row:**
  - If row<ROWS−1: row+1.
  - Otherwise the cursor stays on row ROWS−1, topRow+1, and the FSM enters CLEAR_ROW.
- **Priority:** reset > clear states > input. A write and a read of the same cell in the same cycle returns the old value.

## Timing
- **Reset values** (while rst_n=0):
  - state=CLEAR_ALL, clrIdx=0, topRow=0, cursor=(0,0).
  - inReady=0, rdByte=BLANK.
- **After reset release:**
  - CLEAR_ALL lasts exactly ROWS*COLS cycles.
  - inReady rises on the following edge.
- **Reset asserted mid-clear or mid-scroll:** the operation is abandoned and restarts from the reset state.
- **Read latency:** 1 cycle. An address sampled on edge N gives rdByte valid after edge N.
- **Write visibility:** a byte accepted on edge N is readable with the address presented for edge N+1.
- **Normal bytes:** full throughput; inReady stays high.
- **Scroll:**
  - inReady falls after the edge that accepted the wrapping byte or the LF.
  - It stays low exactly COLS cycles.
- **Form feed (0x0C):** inReady stays low ROWS*COLS cycles.
- **Cursor outputs:** update on the same edge that consumes the byte.
- **Stalled input:** inByte is not sampled while inReady=0. The sender holds it; no byte is lost or duplicated.

## Structure
- **Package uart_text_pkg:**
  - Control-character constants: BS 8'h08, DEL 8'h7F, LF 8'h0A, CR 8'h0D, FF 8'h0C.
  - FSM state enum.
- **Sub-module text_ram:**
  - One synchronous write port and one registered read port.
  - Depth ROWS*COLS, width 8, linear address {physRow, col}.
  - It is the only storage in the block.
- Row-mapping and FSM logic live in the top module.

## Test plan
- **Reset clear:** assert reset with the array pre-loaded with garbage, release → inReady=0 for 64 cycles (4×16), then every cell reads 0x20 and the cursor is (0,0).
- **Wrap:** send "ABCDEFGHIJKLMNOPQ" (17 bytes) → row 0 = "A..P", row 1 col 0 = "Q", cursor=(1,1), inReady never drops.
- **Scroll:** fill rows 0–3 with "0"/"1"/"2"/"3" lines, then send LF → logical row 0 reads "1...", row 3 reads all 0x20, inReady low exactly 16 cycles, cursor=(3,0).
- **Backspace:** send "AB", 0x08 → (0,1) reads 0x20, cursor=(0,1). Send 0x7F at (1,0) → cursor=(0,15) and that cell is blanked. 0x08 at (0,0) → no change.
- **Control characters:** CR mid-line then "Z" → "Z" overwrites col 0 of the same row. 0x0C → 64-cycle clear, cursor=(0,0).
- **Handshake and mid-clear reset:** hold inValid high with "X" during a scroll → accepted exactly once after inReady returns. Assert reset at clear cycle 10 → the full 64-cycle clear restarts.
